// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 mux: registered grant/select/enable, registered Y/valid.
// Latency: req -> grant/s/en in 1 cycle; grant -> Y/valid in 1 more cycle (2 total).
// Backpressure: none downstream; MAX_HOLD caps an owner's tenure while others wait.
module mux_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [3:0]       grant,
  output logic [1:0]       s,
  output logic             en,
  output logic [WIDTH-1:0] Y,
  output logic             valid
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_n;
  logic [1:0]     ptr, ptr_n;
  logic [HW-1:0]  hcnt, hcnt_n;
  logic [3:0]     grant_n;
  logic [1:0]     s_n;
  logic           en_n;

  logic [3:0]     cand_req;
  logic           found;
  logic [1:0]     pick;
  logic           own_req;
  logic           other_req;
  logic           hold_done;
  logic [WIDTH-1:0] mux_out;

  // Candidates exclude the current owner so a forced rotation never re-picks it.
  always_comb begin
    cand_req  = req & ~grant;
    own_req   = |(req & grant);
    other_req = |cand_req;
    hold_done = (hcnt == HOLD_LAST);
  end

  // First candidate in round-robin order starting at ptr.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && cand_req[ptr + 2'(i)]) begin
        found = 1'b1;
        pick  = ptr + 2'(i);
      end
    end
  end

  // Next-state and next-grant logic; a new grant always resets hcnt and advances ptr.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hcnt_n  = hcnt;
    grant_n = grant;
    s_n     = s;
    en_n    = en;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          grant_n = 4'b0001 << pick;
          s_n     = pick;
          en_n    = 1'b1;
          ptr_n   = pick + 2'd1;
          hcnt_n  = '0;
        end
      end
      GRANT: begin
        if (!own_req || (hold_done && other_req)) begin
          if (found) begin
            // Direct handover, no idle bubble.
            grant_n = 4'b0001 << pick;
            s_n     = pick;
            en_n    = 1'b1;
            ptr_n   = pick + 2'd1;
            hcnt_n  = '0;
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
            en_n    = 1'b0;
            hcnt_n  = '0;
          end
        end else if (!hold_done) begin
          hcnt_n = hcnt + HW'(1);
        end
        // Saturated hcnt with no one waiting: owner simply keeps the grant.
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
        en_n    = 1'b0;
      end
    endcase
  end

  // Mux datapath driven by the registered select.
  always_comb begin
    case (s)
      2'd0:    mux_out = A;
      2'd1:    mux_out = B;
      2'd2:    mux_out = C;
      default: mux_out = D;
    endcase
  end

  // State, grant and output registers; reset dominates everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      hcnt  <= '0;
      grant <= 4'b0000;
      s     <= 2'd0;
      en    <= 1'b0;
      Y     <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      hcnt  <= hcnt_n;
      grant <= grant_n;
      s     <= s_n;
      en    <= en_n;
      Y     <= en ? mux_out : '0;
      valid <= en;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized + directed bench for mux_rr_arbiter with a queue-based scoreboard.
// Expectations come from an owner/tenure model tagged with the cycle they apply to.
// A negedge monitor pops and compares every tagged expectation.
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] A, B, C, D;
  logic [3:0]   grant;
  logic [1:0]   s;
  logic         en;
  logic [W-1:0] Y;
  logic         valid;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .A(A), .B(B), .C(C), .D(D),
    .grant(grant), .s(s), .en(en), .Y(Y), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           tag;
    logic [3:0]   g;
    logic [1:0]   s;
    logic         s_chk;
    logic         en;
    logic         v;
    logic [W-1:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: who owns the mux, where the search starts, how long owned.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;

  task automatic model_step(input logic rst, input logic [3:0] r,
                            input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [W-1:0] d2, input logic [W-1:0] d3);
    exp_t e;
    logic [W-1:0] dat[4];
    bit others, rel;
    dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
    e.tag = cyc + 1;
    if (rst) begin
      e.y = '0; e.v = 1'b0;
      m_owner = -1; m_ptr = 0; m_held = 0;
    end else begin
      e.v = (m_owner >= 0);
      e.y = (m_owner >= 0) ? dat[m_owner] : '0;
      others = 0;
      for (int j = 0; j < 4; j++) if (r[j] && j != m_owner) others = 1;
      if (m_owner < 0) rel = 1;
      else rel = !r[m_owner] || (m_held >= MH && others);
      if (rel) begin
        int nxt;
        nxt = -1;
        for (int i = 0; i < 4; i++) begin
          int j;
          j = (m_ptr + i) % 4;
          if (nxt < 0 && r[j] && j != m_owner) nxt = j;
        end
        m_owner = nxt;
        if (nxt >= 0) begin
          m_ptr  = (nxt + 1) % 4;
          m_held = 1;
        end else begin
          m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
    e.en    = (m_owner >= 0);
    e.g     = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.s     = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.s_chk = e.en || rst;
    exp_q.push_back(e);
  endtask

  // One cycle of stimulus: drive, record expectation, advance past the edge.
  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    rst_n = ~rst; req = r; A = a; B = b; C = c; D = d;
    model_step(rst, r, a, b, c, d);
    @(posedge clk);
    #1;
  endtask

  task automatic stepf(input logic rst, input logic [3:0] r);
    step(rst, r, 4'b1000, 4'b1010, 4'b1100, 4'b1111);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant", int'(grant), int'(e.g));
      chk("en",    int'(en),    int'(e.en));
      if (e.s_chk) chk("s", int'(s), int'(e.s));
      chk("valid", int'(valid), int'(e.v));
      chk("Y",     int'(Y),     int'(e.y));
    end
  end

  initial begin
    // Reset held two cycles with every requester active.
    repeat (2) stepf(1'b1, 4'b1111);
    // Full contention: each owner exactly MAX_HOLD cycles.
    repeat (20) stepf(1'b0, 4'b1111);
    stepf(1'b1, 4'b0000);
    stepf(1'b0, 4'b0000);
    // Single requester held well past MAX_HOLD.
    repeat (22) stepf(1'b0, 4'b0100);
    repeat (2) stepf(1'b0, 4'b0000);
    // Early release: A then B with no bubble, then idle.
    repeat (2) stepf(1'b0, 4'b0011);
    repeat (3) stepf(1'b0, 4'b0010);
    repeat (3) stepf(1'b0, 4'b0000);
    // Mid-grant reset while D owns the mux.
    repeat (3) stepf(1'b0, 4'b1000);
    stepf(1'b1, 4'b1111);
    repeat (3) stepf(1'b0, 4'b1111);
    // Fairness with arrival: C joins during A's tenure, then A is regranted.
    stepf(1'b1, 4'b0000);
    repeat (2) stepf(1'b0, 4'b0001);
    repeat (8) stepf(1'b0, 4'b0101);
    repeat (4) stepf(1'b0, 4'b0001);
    repeat (2) stepf(1'b0, 4'b0000);
    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      step($urandom_range(0, 59) == 0, r,
           W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end
    stepf(1'b0, 4'b0000);
    stepf(1'b0, 4'b0000);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
